// File: rtl/apb3_completer_pkg.sv
// Shared types and helpers for the APB3 register-memory completer.
// Window check is done modulo the bus address width so addresses below the base never alias in.
package apb3_completer_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETUP_SEEN = 2'd1,
    ACCESS     = 2'd2
  } state_t;

  localparam int WAIT_W = 4;

  // Offset is computed in aw bits; an address below base wraps to a huge offset and fails.
  function automatic logic addr_in_window(input logic [63:0] paddr,
                                          input logic [63:0] base,
                                          input logic [63:0] window_bytes,
                                          input int unsigned aw);
    logic [63:0] mask;
    logic [63:0] offset;
    mask   = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
    offset = (paddr - base) & mask;
    return offset < window_bytes;
  endfunction

endpackage

// File: rtl/renode_apb3_if.sv
// APB3 bus bundle between one requester and one completer.
// Requester drives address/control/write data; completer drives pready/prdata/pslverr.
interface renode_apb3_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0] paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  logic                    pready;
  logic [DataWidth-1:0]    prdata;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb3_completer_mem.sv
// Depth x DataWidth flop array: one write port, one registered read port (rclr loads zero).
// Read data holds until the next read strobe; no backpressure, write and read are single-cycle.
module apb3_completer_mem #(
  parameter int Depth     = 16,
  parameter int DataWidth = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [DataWidth-1:0]     wdata,
  input  logic                     re,
  input  logic                     rclr,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [DataWidth-1:0]     rdata
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
      if (re) begin
        rdata <= rclr ? '0 : mem_q[raddr];
      end
    end
  end

endmodule

// File: rtl/apb3_completer_synth.sv
// APB3 completer over a small word memory; a transfer takes 2 + WaitStates cycles (setup + access).
// pready is held low for WaitStates access cycles; dropping psel/penable early aborts without side effects.
module apb3_completer_synth
  import apb3_completer_pkg::*;
#(
  parameter int                      AddressWidth = 32,
  parameter int                      DataWidth    = 32,
  parameter int                      Depth        = 16,
  parameter logic [AddressWidth-1:0] BaseAddress  = '0,
  parameter int                      WaitStates   = 0
) (
  input  logic          pclk,
  input  logic          presetn,
  renode_apb3_if.slave  apb
);

  localparam int BytesPerWord = DataWidth / 8;
  localparam int ByteShift    = $clog2(BytesPerWord);
  localparam int IdxW         = $clog2(Depth);
  localparam int WindowBytes  = Depth * BytesPerWord;

  state_t               state_q, state_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic                 cap_write_q, cap_write_d;
  logic                 cap_err_q, cap_err_d;
  logic [IdxW-1:0]      cap_idx_q, cap_idx_d;
  logic [DataWidth-1:0] cap_wdata_q, cap_wdata_d;

  logic                 set_err;
  logic [IdxW-1:0]      set_idx;
  logic                 mem_we, mem_re, mem_rclr;
  logic [IdxW-1:0]      mem_raddr;
  logic [DataWidth-1:0] mem_rdata;

  assign set_err = !addr_in_window(64'(apb.paddr), 64'(BaseAddress), 64'(WindowBytes),
                                   unsigned'(AddressWidth))
                   || ((apb.paddr & AddressWidth'(BytesPerWord - 1)) != '0);
  assign set_idx = IdxW'((apb.paddr - BaseAddress) >> ByteShift);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    cap_write_d = cap_write_q;
    cap_err_d   = cap_err_q;
    cap_idx_d   = cap_idx_q;
    cap_wdata_d = cap_wdata_q;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_rclr    = 1'b0;
    mem_raddr   = cap_idx_q;

    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d     = SETUP_SEEN;
          cnt_d       = WAIT_W'(WaitStates);
          cap_write_d = apb.pwrite;
          cap_err_d   = set_err;
          cap_idx_d   = set_idx;
          cap_wdata_d = apb.pwdata;
          if (WaitStates == 0) begin
            pready_d  = 1'b1;
            pslverr_d = set_err;
            mem_re    = !apb.pwrite;
            mem_rclr  = set_err;
            mem_raddr = set_idx;
          end
        end
      end

      SETUP_SEEN, ACCESS: begin
        if (!(apb.psel && apb.penable)) begin
          // Requester left the access phase early: drop everything, commit nothing.
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          mem_we    = cap_write_q && !cap_err_q;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = ACCESS;
          if (cnt_q != '0) begin
            cnt_d = WAIT_W'(cnt_q - 1'b1);
          end
          if (cnt_q == WAIT_W'(1)) begin
            pready_d  = 1'b1;
            pslverr_d = cap_err_q;
            mem_re    = !cap_write_q;
            mem_rclr  = cap_err_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      cap_write_q <= 1'b0;
      cap_err_q   <= 1'b0;
      cap_idx_q   <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      cap_write_q <= cap_write_d;
      cap_err_q   <= cap_err_d;
      cap_idx_q   <= cap_idx_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  apb3_completer_mem #(
    .Depth     (Depth),
    .DataWidth (DataWidth)
  ) u_mem (
    .clk   (pclk),
    .rst_n (presetn),
    .we    (mem_we),
    .waddr (cap_idx_q),
    .wdata (cap_wdata_q),
    .re    (mem_re),
    .rclr  (mem_rclr),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign apb.pready  = pready_q;
  assign apb.prdata  = mem_rdata;
  assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb3_completer_synth.sv
// Bench for apb3_completer_synth: three instances (WaitStates 0/3/2) on a shared requester model.
// Directed vector table, multi-cycle abort/reset sequences, then random traffic against a memory model.
module tb_apb3_completer_synth;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          MAXW = 40;

  logic        clk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [2:0]  psel = '0;
  logic [2:0]  pready;
  logic [2:0]  pslverr;
  logic [31:0] prdata [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [3][16];

  always #5 clk = ~clk;

  renode_apb3_if bus0 ();
  renode_apb3_if bus1 ();
  renode_apb3_if bus2 ();

  assign bus0.paddr = paddr;  assign bus0.pwdata = pwdata;
  assign bus0.penable = penable; assign bus0.pwrite = pwrite; assign bus0.psel = psel[0];
  assign bus1.paddr = paddr;  assign bus1.pwdata = pwdata;
  assign bus1.penable = penable; assign bus1.pwrite = pwrite; assign bus1.psel = psel[1];
  assign bus2.paddr = paddr;  assign bus2.pwdata = pwdata;
  assign bus2.penable = penable; assign bus2.pwrite = pwrite; assign bus2.psel = psel[2];

  assign pready[0] = bus0.pready; assign pslverr[0] = bus0.pslverr; assign prdata[0] = bus0.prdata;
  assign pready[1] = bus1.pready; assign pslverr[1] = bus1.pslverr; assign prdata[1] = bus1.prdata;
  assign pready[2] = bus2.pready; assign pslverr[2] = bus2.pslverr; assign prdata[2] = bus2.prdata;

  apb3_completer_synth #(.BaseAddress(BASE), .WaitStates(0)) dut0 (.pclk(clk), .presetn(presetn), .apb(bus0));
  apb3_completer_synth #(.BaseAddress(BASE), .WaitStates(3)) dut1 (.pclk(clk), .presetn(presetn), .apb(bus1));
  apb3_completer_synth #(.BaseAddress(BASE), .WaitStates(2)) dut2 (.pclk(clk), .presetn(presetn), .apb(bus2));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >= 32'd64) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] model_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return off[3:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_cycle();
    psel = '0;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  // Setup cycle, then access cycles until pready; returns at posedge+1 after completion.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int cyc);
    bit done;
    done = 1'b0;
    rd = '0; err = 1'b0; cyc = 1;
    psel = '0; psel[d] = 1'b1;
    penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < MAXW && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (pready[d]) begin
        rd = prdata[d];
        err = pslverr[d];
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: dut%0d addr %h got no pready within %0d cycles", d, a, MAXW);
      psel = '0; penable = 1'b0;
    end
  endtask

  task automatic model_apply(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd);
    if (w && !model_err(a)) mdl[d][model_idx(a)] = wd;
  endtask

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic        w;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [31:0] rd, a, wd, exp_rd;
    logic        err, w, exp_err;
    int          cyc, d;

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++) mdl[i][j] = '0;

    tbl[0]  = '{0, 32'h0000_1008, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0, 2};
    tbl[1]  = '{0, 32'h0000_1008, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 2};
    tbl[2]  = '{0, 32'h0000_1040, 1'b1, 32'h1111_1111, 32'h0,         1'b1, 2};
    tbl[3]  = '{0, 32'h0000_1002, 1'b1, 32'h2222_2222, 32'h0,         1'b1, 2};
    tbl[4]  = '{0, 32'h0000_1040, 1'b0, 32'h0,         32'h0,         1'b1, 2};
    tbl[5]  = '{0, 32'h0000_1000, 1'b0, 32'h0,         32'h0,         1'b0, 2};
    tbl[6]  = '{0, 32'h0000_0FFC, 1'b0, 32'h0,         32'h0,         1'b1, 2};
    tbl[7]  = '{0, 32'h0000_103C, 1'b0, 32'h0,         32'h0,         1'b0, 2};
    tbl[8]  = '{1, 32'h0000_1004, 1'b1, 32'hCAFE_F00D, 32'h0,         1'b0, 5};
    tbl[9]  = '{1, 32'h0000_1004, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0, 5};
    tbl[10] = '{1, 32'h0000_1041, 1'b0, 32'h0,         32'h0,         1'b1, 5};
    tbl[11] = '{2, 32'h0000_1010, 1'b1, 32'hA5A5_A5A5, 32'h0,         1'b0, 4};
    tbl[12] = '{2, 32'h0000_1010, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0, 4};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst pready dut%0d", i), {31'b0, pready[i]}, 32'h0);
      chk($sformatf("rst pslverr dut%0d", i), {31'b0, pslverr[i]}, 32'h0);
      chk($sformatf("rst prdata dut%0d", i), prdata[i], 32'h0);
    end
    @(negedge clk); presetn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      xfer(tbl[i].d, tbl[i].addr, tbl[i].w, tbl[i].wd, rd, err, cyc);
      model_apply(tbl[i].d, tbl[i].addr, tbl[i].w, tbl[i].wd);
      chk($sformatf("vec%0d pslverr", i), {31'b0, err}, {31'b0, tbl[i].err});
      chk($sformatf("vec%0d cycles", i), cyc, tbl[i].cyc);
      if (!tbl[i].w) chk($sformatf("vec%0d prdata", i), rd, tbl[i].rd);
      idle_cycle();
    end

    // Back-to-back writes then reads, no idle cycles between transfers
    for (int i = 0; i < 16; i++) begin
      xfer(0, BASE + 32'(i * 4), 1'b1, 32'(i), rd, err, cyc);
      model_apply(0, BASE + 32'(i * 4), 1'b1, 32'(i));
      chk($sformatf("b2b wr%0d cycles", i), cyc, 2);
    end
    for (int i = 0; i < 16; i++) begin
      xfer(0, BASE + 32'(i * 4), 1'b0, 32'h0, rd, err, cyc);
      chk($sformatf("b2b rd%0d cycles", i), cyc, 2);
      chk($sformatf("b2b rd%0d prdata", i), rd, 32'(i));
    end
    idle_cycle();

    // psel dropped during a WaitStates=3 write: no pready, word keeps old value
    psel = 3'b010; penable = 1'b0; paddr = 32'h0000_1004; pwrite = 1'b1; pwdata = 32'h1234_5678;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); chk("abort pready acc1", {31'b0, pready[1]}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("abort pready acc2", {31'b0, pready[1]}, 32'h0);
    @(posedge clk); #1; psel = '0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (4) begin @(negedge clk); seen = seen | pready[1]; end
      chk("abort pready after drop", {31'b0, seen}, 32'h0);
    end
    penable = 1'b0;
    @(posedge clk); #1;
    xfer(1, 32'h0000_1004, 1'b0, 32'h0, rd, err, cyc);
    chk("abort word kept", rd, 32'hCAFE_F00D);
    chk("abort next cycles", cyc, 5);
    idle_cycle();

    // Random traffic against the memory model
    for (int n = 0; n < 150; n++) begin
      d  = $urandom_range(0, 2);
      w  = $urandom_range(0, 1);
      wd = $urandom;
      a  = BASE + 32'($urandom_range(0, 72));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) a = BASE - 32'd4;
      exp_err = model_err(a);
      exp_rd  = exp_err ? 32'h0 : mdl[d][model_idx(a)];
      xfer(d, a, w, wd, rd, err, cyc);
      model_apply(d, a, w, wd);
      chk($sformatf("rnd%0d pslverr", n), {31'b0, err}, {31'b0, exp_err});
      chk($sformatf("rnd%0d cycles", n), cyc, 2 + ws_of(d));
      if (!w) chk($sformatf("rnd%0d prdata a=%h", n, a), rd, exp_rd);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    // Make dut2's prdata nonzero, then reset in the middle of a WaitStates=2 write
    xfer(2, 32'h0000_1018, 1'b1, 32'h7777_0001, rd, err, cyc);
    xfer(2, 32'h0000_1018, 1'b0, 32'h0, rd, err, cyc);
    chk("pre-reset readback", rd, 32'h7777_0001);
    psel = 3'b100; penable = 1'b0; paddr = 32'h0000_1010; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); presetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst pready dut%0d", i), {31'b0, pready[i]}, 32'h0);
      chk($sformatf("midrst pslverr dut%0d", i), {31'b0, pslverr[i]}, 32'h0);
      chk($sformatf("midrst prdata dut%0d", i), prdata[i], 32'h0);
    end
    psel = '0; penable = 1'b0;
    @(posedge clk); #1;
    presetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      xfer(2, BASE + 32'(i * 4), 1'b0, 32'h0, rd, err, cyc);
      chk($sformatf("post-rst word%0d", i), rd, 32'h0);
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
